// File: rtl/bsg_upstream_link_arbiter_if.sv
// Requester/link bundle for the upstream link arbiter.
// The slave modport is the arbiter's view; the master modport is the core-side/link environment.
interface bsg_upstream_link_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int CREDIT_MAX = 8
);
   localparam int SRCW = $clog2(NUM_REQ);
   localparam int CW   = $clog2(CREDIT_MAX + 1);

   logic [NUM_REQ-1:0]    req_valid;
   logic [64*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]    req_ready;
   logic                  io_token;
   logic                  link_valid;
   logic [63:0]           link_data;
   logic [SRCW-1:0]       link_src;
   logic                  link_ready;
   logic [CW-1:0]         credits;
   logic                  err_overflow;

   modport slave (
      input  req_valid, req_data, io_token, link_ready,
      output req_ready, link_valid, link_data, link_src, credits, err_overflow
   );

   modport master (
      output req_valid, req_data, io_token, link_ready,
      input  req_ready, link_valid, link_data, link_src, credits, err_overflow
   );
endinterface

// File: rtl/bsg_upstream_link_arbiter.sv
// Round-robin, credit-gated arbiter sharing one upstream link among NUM_REQ requesters.
// Optional macro BSG_UPSTREAM_ARB_PRIO0_EN gives requester 0 absolute priority.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no packet held; grant a requester when credits allow
// ST_BUSY | packet held on the link until the serializer takes it
module bsg_upstream_link_arbiter #(
   parameter int NUM_REQ       = 4,
   parameter int CREDIT_MAX    = 8,
   parameter int TOKEN_CREDITS = 4,
   parameter int PKT_CREDITS   = 2
) (
   input logic                       clk,
   input logic                       rst_n,
   bsg_upstream_link_arbiter_if.slave lif
);
   localparam int SRCW = $clog2(NUM_REQ);
   localparam int CW   = $clog2(CREDIT_MAX + 1);
   localparam int SW   = CW + 1;

   typedef enum logic {ST_IDLE, ST_BUSY} state_e;

   state_e             state_q, state_d;
   logic [SRCW-1:0]    rr_q, rr_d;
   logic [SRCW-1:0]    src_q, src_d;
   logic [63:0]        data_q, data_d;
   logic [CW-1:0]      credits_q, credits_d;
   logic               ovf_q, ovf_d;

   logic [NUM_REQ-1:0] win_oh;
   logic [SRCW-1:0]    win_idx;
   logic [SRCW-1:0]    idx_c;
   logic [63:0]        win_data;
   logic               win_found;
   logic               prio_win;
   logic               eligible;
   logic               grant;
   logic [SW-1:0]      credit_sum;

   // First valid requester above the rr pointer, wrapping around.
   always_comb begin
      win_oh    = '0;
      win_idx   = '0;
      idx_c     = '0;
      win_found = 1'b0;
      prio_win  = 1'b0;
`ifdef BSG_UPSTREAM_ARB_PRIO0_EN
      if (lif.req_valid[0]) begin
         win_oh[0] = 1'b1;
         win_found = 1'b1;
         prio_win  = 1'b1;
      end
`endif
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx_c = SRCW'((int'(rr_q) + k) % NUM_REQ);
         if (!win_found && lif.req_valid[idx_c]) begin
            win_oh[idx_c] = 1'b1;
            win_idx       = idx_c;
            win_found     = 1'b1;
         end
      end
   end

   always_comb begin
      win_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_oh[i]) win_data = lif.req_data[i*64 +: 64];
      end
   end

   assign eligible = (|lif.req_valid) && (credits_q >= CW'(PKT_CREDITS));

   always_comb begin
      state_d       = state_q;
      rr_d          = rr_q;
      src_d         = src_q;
      data_d        = data_q;
      grant         = 1'b0;
      lif.req_ready = '0;
      case (state_q)
         ST_IDLE: begin
            if (eligible && win_found) begin
               grant         = 1'b1;
               lif.req_ready = win_oh;
               data_d        = win_data;
               src_d         = win_idx;
               if (!prio_win) rr_d = win_idx;
               state_d       = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (lif.link_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Net credit change is applied first, then saturated; the extra bit holds the overshoot.
   always_comb begin
      credits_d  = credits_q;
      ovf_d      = ovf_q;
      credit_sum = SW'(credits_q)
                 + (lif.io_token ? SW'(TOKEN_CREDITS) : '0)
                 - (grant ? SW'(PKT_CREDITS) : '0);
      if (credit_sum > SW'(CREDIT_MAX)) begin
         credits_d = CW'(CREDIT_MAX);
         ovf_d     = 1'b1;
      end else begin
         credits_d = credit_sum[CW-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         rr_q      <= SRCW'(NUM_REQ - 1);
         src_q     <= '0;
         data_q    <= '0;
         credits_q <= CW'(CREDIT_MAX);
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         rr_q      <= rr_d;
         src_q     <= src_d;
         data_q    <= data_d;
         credits_q <= credits_d;
         ovf_q     <= ovf_d;
      end
   end

   assign lif.link_valid   = (state_q == ST_BUSY);
   assign lif.link_data    = data_q;
   assign lif.link_src     = src_q;
   assign lif.credits      = credits_q;
   assign lif.err_overflow = ovf_q;
endmodule

// File: tb/tb_bsg_upstream_link_arbiter.sv
// Randomized and directed checks of the upstream link arbiter against a
// queue/arithmetic model of the arbitration and credit rules.
module tb_bsg_upstream_link_arbiter;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   bsg_upstream_link_arbiter_if #(.NUM_REQ(4), .CREDIT_MAX(8)) lif ();

   bsg_upstream_link_arbiter #(
      .NUM_REQ(4), .CREDIT_MAX(8), .TOKEN_CREDITS(4), .PKT_CREDITS(2)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .lif  (lif.slave)
   );

   int tests = 0;
   int fails = 0;

   // Model state
   int          m_cred;
   bit          m_busy;
   logic [63:0] m_data;
   int          m_src;
   bit          m_ovf;
   int          m_ptr;
   int          gq[$];

   function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endfunction

   function automatic void model_reset();
      m_cred = 8;
      m_busy = 1'b0;
      m_data = '0;
      m_src  = 0;
      m_ovf  = 1'b0;
      m_ptr  = 3;
   endfunction

   function automatic logic [255:0] rnd256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // One link cycle: drive, compare against the model, advance the model.
   task automatic step(input logic [3:0] v, input logic [255:0] d, input bit tok, input bit lr);
      int win;
      bit pwin;
      int nc;
      logic [3:0] exp_rdy;
      @(negedge clk);
      lif.req_valid  = v;
      lif.req_data   = d;
      lif.io_token   = tok;
      lif.link_ready = lr;
      #1;
      win  = -1;
      pwin = 1'b0;
      if (!m_busy && v != 4'b0 && m_cred >= 2) begin
`ifdef BSG_UPSTREAM_ARB_PRIO0_EN
         if (v[0]) begin
            win  = 0;
            pwin = 1'b1;
         end
`endif
         for (int k = 1; k <= 4 && win < 0; k++)
            if (v[(m_ptr + k) % 4]) win = (m_ptr + k) % 4;
      end
      exp_rdy = (win >= 0) ? 4'(1 << win) : 4'b0;
      chk("req_ready",    64'(lif.req_ready),    64'(exp_rdy));
      chk("link_valid",   64'(lif.link_valid),   64'(m_busy));
      chk("link_data",    lif.link_data,         m_data);
      chk("link_src",     64'(lif.link_src),     64'(m_src));
      chk("credits",      64'(lif.credits),      64'(m_cred));
      chk("err_overflow", 64'(lif.err_overflow), 64'(m_ovf));
      nc = m_cred + (tok ? 4 : 0) - ((win >= 0) ? 2 : 0);
      if (nc > 8) begin
         nc    = 8;
         m_ovf = 1'b1;
      end
      m_cred = nc;
      if (win >= 0) begin
         m_busy = 1'b1;
         m_data = d[win*64 +: 64];
         m_src  = win;
         if (!pwin) m_ptr = win;
         gq.push_back(win);
      end else if (m_busy && lr) begin
         m_busy = 1'b0;
      end
   endtask

   task automatic sync_reset_start();
      lif.req_valid  = '0;
      lif.req_data   = '0;
      lif.io_token   = 1'b0;
      lif.link_ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      model_reset();
      gq.delete();
   endtask

   logic [63:0] held;
   int          g0;

   initial begin
      rst_n          = 1'b0;
      lif.req_valid  = '0;
      lif.req_data   = '0;
      lif.io_token   = 1'b0;
      lif.link_ready = 1'b0;
      model_reset();
      #12;
      rst_n = 1'b1;

      // Reset values
      chk("rst_link_valid", 64'(lif.link_valid), 64'd0);
      chk("rst_credits",    64'(lif.credits),    64'd8);
      chk("rst_ovf",        64'(lif.err_overflow), 64'd0);
      chk("rst_src",        64'(lif.link_src),   64'd0);

      // Single requester 0
      step(4'b0001, {192'b0, 64'hDEAD_BEEF_0123_4567}, 1'b0, 1'b1);
      chk("t1_ready_c0", 64'(lif.req_ready), 64'h1);
      step(4'b0000, '0, 1'b0, 1'b1);
      chk("t1_valid_c1", 64'(lif.link_valid), 64'd1);
      chk("t1_data_c1",  lif.link_data, 64'hDEAD_BEEF_0123_4567);
      chk("t1_src_c1",   64'(lif.link_src), 64'd0);
      chk("t1_cred_c1",  64'(lif.credits), 64'd6);

      // Continuous requests with tokens every cycle: rr order, one grant per 2 cycles
      sync_reset_start();
      for (int i = 0; i < 10; i++) step(4'b1111, rnd256(), 1'b1, 1'b1);
      chk("t2_ngrants", 64'(gq.size()), 64'd5);
      if (gq.size() == 5) begin
         chk("t2_g0", 64'(gq[0]), 64'd0);
         chk("t2_g1", 64'(gq[1]), 64'd1);
         chk("t2_g2", 64'(gq[2]), 64'd2);
         chk("t2_g3", 64'(gq[3]), 64'd3);
         chk("t2_g4", 64'(gq[4]), 64'd0);
      end

      // No tokens: four packets then stall; one token releases two more
      sync_reset_start();
      for (int i = 0; i < 20; i++) step(4'b1111, rnd256(), 1'b0, 1'b1);
      chk("t3_ngrants", 64'(gq.size()), 64'd4);
      chk("t3_cred0",   64'(lif.credits), 64'd0);
      step(4'b0000, '0, 1'b1, 1'b1);
      step(4'b0000, '0, 1'b0, 1'b1);
      chk("t3_cred4",   64'(lif.credits), 64'd4);
      g0 = gq.size();
      for (int i = 0; i < 20; i++) step(4'b1111, rnd256(), 1'b0, 1'b1);
      chk("t3_more",    64'(gq.size() - g0), 64'd2);
      chk("t3_cred_end", 64'(lif.credits), 64'd0);

      // Token overflow is sticky
      sync_reset_start();
      step(4'b0001, rnd256(), 1'b0, 1'b1);
      step(4'b0000, '0, 1'b0, 1'b1);
      step(4'b0000, '0, 1'b1, 1'b1);
      step(4'b0000, '0, 1'b0, 1'b1);
      chk("t4_cred", 64'(lif.credits), 64'd8);
      chk("t4_ovf",  64'(lif.err_overflow), 64'd1);
      for (int i = 0; i < 4; i++) step(4'b0000, '0, 1'b0, 1'b1);
      chk("t4_ovf_sticky", 64'(lif.err_overflow), 64'd1);

      // Grant and token together at credits=2, then a long link stall
      sync_reset_start();
      for (int i = 0; i < 6; i++) step(4'b1111, rnd256(), 1'b0, 1'b1);
      chk("t5_cred2", 64'(lif.credits), 64'd2);
      step(4'b1111, rnd256(), 1'b1, 1'b0);
      step(4'b1111, rnd256(), 1'b0, 1'b0);
      chk("t5_cred4", 64'(lif.credits), 64'd4);
      held = lif.link_data;
      for (int i = 0; i < 4; i++) begin
         step(4'b1111, rnd256(), 1'b0, 1'b0);
         chk("t5_hold_data",  lif.link_data, held);
         chk("t5_no_ready",   64'(lif.req_ready), 64'd0);
      end

      // Async reset while busy
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", 64'(lif.link_valid), 64'd0);
      chk("t6_rst_cred",  64'(lif.credits), 64'd8);
      #1;
      rst_n = 1'b1;
      model_reset();
      lif.req_valid = '0;
      step(4'b1110, rnd256(), 1'b0, 1'b1);
      chk("t6_first", 64'(lif.req_ready), 64'b0010);
      step(4'b0000, '0, 1'b0, 1'b1);
      step(4'b1111, rnd256(), 1'b0, 1'b1);
`ifdef BSG_UPSTREAM_ARB_PRIO0_EN
      chk("t6_prio0", 64'(lif.req_ready), 64'b0001);
`else
      chk("t6_rr",    64'(lif.req_ready), 64'b0100);
`endif

      // Randomized traffic
      sync_reset_start();
      for (int i = 0; i < 3000; i++)
         step(4'($urandom_range(0, 15)), rnd256(),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
